// File: rtl/usb_rx_pkg.sv
// Shared bus levels, FSM state type and parameter defaults for the USB receive front end.
package usb_rx_pkg;

  localparam logic [1:0] BUS_SE0 = 2'b00;
  localparam logic [1:0] BUS_K   = 2'b01;
  localparam logic [1:0] BUS_J   = 2'b10;
  localparam logic [1:0] BUS_ILL = 2'b11;

  localparam int SYNC_ZEROS_DEF  = 7;
  localparam int STUFF_LIMIT_DEF = 6;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/rx_unstuff.sv
// Consecutive-ones tracker: marks the bit after STUFF_LIMIT ones as stuffed (dropped).
// USB_RX_STUFF_CHECK_EN: when defined, a one in the stuffed position is flagged as a violation.
module rx_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load_one,
  input  logic bit_strobe,
  input  logic bit_in,
  output logic drop,
  output logic violation
);

  logic [2:0] ones;
  logic [2:0] ones_n;
  logic       at_limit;

  assign at_limit = (ones == 3'(STUFF_LIMIT));
  assign drop     = bit_strobe && at_limit;

`ifdef USB_RX_STUFF_CHECK_EN
  assign violation = bit_strobe && at_limit && bit_in;
`else
  assign violation = 1'b0;
`endif

  // The SYNC terminating one counts toward the run, hence load_one.
  always_comb begin
    ones_n = ones;
    if (clear) begin
      ones_n = '0;
    end else if (load_one) begin
      ones_n = 3'd1;
    end else if (bit_strobe) begin
      if (at_limit || !bit_in) ones_n = '0;
      else                     ones_n = sat_inc3(ones);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ones <= '0;
    else     ones <= ones_n;
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive front end: SYNC detect, NRZI decode, unstuffing and EOP detect, one bus bit per clock.
// USB_RX_STUFF_CHECK_EN (in rx_unstuff): stuff violations raise rx_error instead of being dropped.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int SYNC_ZEROS  = SYNC_ZEROS_DEF,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] host_in,
  input  logic       enable,
  output logic       s_out,
  output logic       s_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       rx_error,
  output rx_state_t  dbg_state
);

  // Handshake: no backpressure; s_out is meaningful only in cycles where s_valid is high,
  // and pkt_start/pkt_end/rx_error are single-cycle pulses.

  rx_state_t  state, state_n;
  logic [1:0] prev_level, prev_level_n;
  logic [2:0] zcnt, zcnt_n;
  logic       eop_two, eop_two_n;
  logic       s_out_n, s_valid_n, pkt_start_n, pkt_end_n, rx_error_n;
  logic       is_jk, dec_bit, load_one, bit_strobe, drop, violation, go_err;

  assign is_jk     = (host_in == BUS_J) || (host_in == BUS_K);
  assign dec_bit   = (host_in == prev_level);
  assign dbg_state = state;

  rx_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_unstuff (
    .clk        (clk),
    .rst        (rst),
    .clear      (enable),
    .load_one   (load_one),
    .bit_strobe (bit_strobe),
    .bit_in     (dec_bit),
    .drop       (drop),
    .violation  (violation)
  );

  always_comb begin
    state_n      = state;
    prev_level_n = is_jk ? host_in : prev_level;
    zcnt_n       = zcnt;
    eop_two_n    = eop_two;
    s_out_n      = 1'b0;
    s_valid_n    = 1'b0;
    pkt_start_n  = 1'b0;
    pkt_end_n    = 1'b0;
    rx_error_n   = 1'b0;
    load_one     = 1'b0;
    bit_strobe   = 1'b0;
    go_err       = 1'b0;
    if (enable) begin
      state_n      = IDLE;
      prev_level_n = BUS_J;
      zcnt_n       = '0;
      eop_two_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_jk && !dec_bit) begin
            zcnt_n  = 3'd1;
            state_n = SYNC;
          end
        end
        SYNC: begin
          if (!is_jk) begin
            go_err = 1'b1;
          end else if (dec_bit) begin
            if (zcnt == 3'(SYNC_ZEROS)) begin
              pkt_start_n = 1'b1;
              load_one    = 1'b1;
              state_n     = DATA;
            end else begin
              go_err = 1'b1;
            end
          end else if (zcnt == 3'(SYNC_ZEROS)) begin
            go_err = 1'b1;
          end else begin
            zcnt_n = sat_inc3(zcnt);
          end
        end
        DATA: begin
          if (host_in == BUS_SE0) begin
            state_n   = EOP;
            eop_two_n = 1'b0;
          end else if (!is_jk) begin
            go_err = 1'b1;
          end else begin
            bit_strobe = 1'b1;
            if (violation) begin
              go_err = 1'b1;
            end else if (!drop) begin
              s_out_n   = dec_bit;
              s_valid_n = 1'b1;
            end
          end
        end
        EOP: begin
          if (host_in == BUS_J) begin
            pkt_end_n = 1'b1;
            state_n   = IDLE;
          end else if (host_in == BUS_SE0 && !eop_two) begin
            eop_two_n = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
        ERR: begin
          if (host_in == BUS_J) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
      if (go_err) begin
        state_n    = ERR;
        rx_error_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_level <= BUS_J;
      zcnt       <= '0;
      eop_two    <= 1'b0;
      s_out      <= 1'b0;
      s_valid    <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      prev_level <= prev_level_n;
      zcnt       <= zcnt_n;
      eop_two    <= eop_two_n;
      s_out      <= s_out_n;
      s_valid    <= s_valid_n;
      pkt_start  <= pkt_start_n;
      pkt_end    <= pkt_end_n;
      rx_error   <= rx_error_n;
    end
  end

endmodule
